banked_ram_ctrl: RTL and testbench

Parametrised banked data memory with a valid/ready request port, per-lane write enables, a registered read response with backpressure, and a hardware zero-fill after reset. It generalises the fixed four-bank, two-slice RAM to 2^BANK_BITS banks of LANES slices each. It sits between the datapath's load/store unit and storage.

---
 rtl/banked_ram_pkg.sv | 22 ++
 rtl/banked_ram_lane.sv | 30 +++
 rtl/banked_ram_ctrl.sv | 139 +++++++++++++
 tb/tb_banked_ram_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/banked_ram_pkg.sv
// Shared types, default sizes and sizing helpers for the banked data memory.
package banked_ram_pkg;

    typedef enum logic {INIT, RUN} state_e;

    // Default geometry, also used by the load/store unit.
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_BANK_BITS  = 2;
    localparam int DEF_LANES      = 2;

    // Rows per bank.
    function automatic int calc_depth(input int addr_width, input int bank_bits);
        return 1 << (addr_width - bank_bits);
    endfunction

    // Bits per independently writable lane.
    function automatic int calc_lane_w(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

endpackage

// File: rtl/banked_ram_lane.sv
// One bank-lane slice: LANE_W x DEPTH storage, synchronous write, registered read.
module banked_ram_lane #(
    parameter int LANE_W = 8,
    parameter int ROW_W  = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ROW_W-1:0]  addr,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rdata_q;

    // Storage write and read-data register; contents carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_ram_ctrl.sv
// Banked data memory: zero-fill after reset, valid/ready requests,
// per-lane writes and a one-cycle registered read response with backpressure.
module banked_ram_ctrl
    import banked_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BANK_BITS  = DEF_BANK_BITS,
    parameter int LANES      = DEF_LANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LANES-1:0]      req_lane_en,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
);

    localparam int ROW_W  = ADDR_WIDTH - BANK_BITS;
    localparam int NBANKS = 1 << BANK_BITS;
    localparam int DEPTH  = calc_depth(ADDR_WIDTH, BANK_BITS);
    localparam int LANE_W = calc_lane_w(DATA_WIDTH, LANES);

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     fill_q, fill_d;
    logic                 fill_last_q, fill_last_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 init_done_q, init_done_d;
    logic [BANK_BITS-1:0] rsp_bank_q, rsp_bank_d;

    logic [BANK_BITS-1:0] req_bank;
    logic [ROW_W-1:0]     req_row;
    logic                 accept;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 fill_we;
    logic                 filling;
    logic [ROW_W-1:0]     mem_addr;
    logic [NBANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

    assign req_bank  = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign req_row   = req_addr[ROW_W-1:0];
    assign filling   = (state_q == INIT);
    assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
    // A request on the reset edge is dropped rather than allowed to touch storage.
    assign accept    = req_valid && req_ready && rst_n;
    assign rd_acc    = accept && !req_write;
    assign wr_acc    = accept && req_write;
    // Once the last row is written, one extra INIT cycle flags completion without writing.
    assign fill_we   = filling && !fill_last_q;
    assign mem_addr  = filling ? fill_q : req_row;

    // Next-state logic for the fill sequencer and the response handshake.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        fill_last_d = fill_last_q;
        rsp_valid_d = rsp_valid_q;
        init_done_d = init_done_q;
        rsp_bank_d  = rsp_bank_q;
        case (state_q)
            INIT: begin
                rsp_valid_d = 1'b0;
                if (fill_last_q) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    fill_d      = fill_q + 1'b1;
                    fill_last_d = (fill_q == ROW_W'(DEPTH - 1));
                end
            end
            RUN: begin
                if (rd_acc) begin
                    rsp_valid_d = 1'b1;
                    rsp_bank_d  = req_bank;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Control state with synchronous active-low reset; the response bank select is data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            fill_q      <= '0;
            fill_last_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            fill_last_q <= fill_last_d;
            rsp_valid_q <= rsp_valid_d;
            init_done_q <= init_done_d;
        end
        rsp_bank_q <= rsp_bank_d;
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic bank_hit;
        assign bank_hit = (req_bank == BANK_BITS'(b));
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic              lane_we;
            logic              lane_re;
            logic [LANE_W-1:0] lane_wdata;
            assign lane_we    = fill_we || (wr_acc && bank_hit && req_lane_en[l]);
            assign lane_re    = rd_acc && bank_hit;
            assign lane_wdata = filling ? '0 : req_wdata[l*LANE_W +: LANE_W];
            banked_ram_lane #(
                .LANE_W (LANE_W),
                .ROW_W  (ROW_W),
                .DEPTH  (DEPTH)
            ) u_lane (
                .clk   (clk),
                .we    (lane_we),
                .re    (lane_re),
                .addr  (mem_addr),
                .wdata (lane_wdata),
                .rdata (bank_rdata[b][l*LANE_W +: LANE_W])
            );
        end
    end

    // Lane read registers only load on an accepted read to their bank, so the
    // selected bank output holds through backpressure and across writes.
    assign rsp_rdata = rsp_valid_q ? bank_rdata[rsp_bank_q] : '0;
    assign rsp_valid = rsp_valid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Directed bench for banked_ram_ctrl with default geometry (4 banks x 2 lanes, 1024 rows).
module tb_banked_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_lane_en;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    banked_ram_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_lane_en (req_lane_en),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects init_done/req_ready low for 1024 edges after release, then both high.
    task automatic wait_fill(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            if (init_done !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        chk({tag, "_hold"}, bad, 0);
        @(posedge clk); #1;
        chk({tag, "_done"}, init_done, 1);
        chk({tag, "_rdy"}, req_ready, 1);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d,
                            input logic [1:0] en, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a;
        req_wdata = d; req_lane_en = en; rsp_ready = 1'b1;
        #1 chk({tag, "_rdy"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_rdata, exp);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_lane_en = '0; rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk("rst_init_done", init_done, 0);

        // Release reset with a write held at the port: it must not land during the fill
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'hFFF;
        req_wdata = 16'h5555; req_lane_en = 2'b11;
        wait_fill("fill1");
        do_read(12'hFFF, 16'h0000, "rd_fff_zero");

        // Write then read
        do_write(12'h000, 16'hBEEF, 2'b11, "wr_000");
        do_read(12'h000, 16'hBEEF, "rd_000");

        // Lane enables: only the upper lane is replaced
        do_write(12'hC05, 16'h1234, 2'b11, "wr_c05_full");
        do_write(12'hC05, 16'hAB00, 2'b10, "wr_c05_hi");
        do_read(12'hC05, 16'hAB34, "rd_c05_lane");

        // Bank isolation at the same row index
        do_write(12'h005, 16'h1111, 2'b11, "wr_b0");
        do_write(12'h405, 16'h2222, 2'b11, "wr_b1");
        do_write(12'h805, 16'h3333, 2'b11, "wr_b2");
        do_write(12'hC05, 16'h4444, 2'b11, "wr_b3");
        do_read(12'h005, 16'h1111, "rd_b0");
        do_read(12'h405, 16'h2222, "rd_b1");
        do_read(12'h805, 16'h3333, "rd_b2");
        do_read(12'hC05, 16'h4444, "rd_b3");

        // Backpressure: response held, next read waits until rsp_ready
        idle_cycle();
        chk("drain_vld", rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h000; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 12'h405;
        chk("bp_first_vld", rsp_valid, 1);
        chk("bp_first_data", rsp_rdata, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_vld", rsp_valid, 1);
            chk("bp_hold_data", rsp_rdata, 16'hBEEF);
            chk("bp_hold_rdy", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_release_rdy", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_vld", rsp_valid, 1);
        chk("bp_next_data", rsp_rdata, 16'h2222);
        @(posedge clk); #1;
        chk("bp_clear", rsp_valid, 0);

        // Read after write to the same address
        do_write(12'h405, 16'h9999, 2'b11, "raw_wr");
        do_read(12'h405, 16'h9999, "raw_rd");

        // Reset while a response is pending
        @(negedge clk);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1 chk("pre_rst_vld", rsp_valid, 1);
        @(posedge clk); #1;
        chk("midrst_vld", rsp_valid, 0);
        chk("midrst_done", init_done, 0);
        chk("midrst_rdy", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_fill("fill2");
        do_read(12'h000, 16'h0000, "rd_000_cleared");
        do_read(12'h405, 16'h0000, "rd_405_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
